// File: rtl/cpu_fetch_responder.sv
// Read-only instruction-fetch target: BRAM behind a request/ready bus with programmable wait states.
// Optional transfer/error statistics enabled by defining FETCH_RESPONDER_STATS_EN.
module cpu_fetch_responder #(
  parameter int unsigned SIZE        = 12,
  parameter logic [31:0] BASE        = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] FILL_WORD   = 32'h0000_0000
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_bus_request,
  input  logic [31:0]     i_bus_address,
  output logic            o_bus_ready,
  output logic [31:0]     o_bus_rdata,
  output logic            o_bus_error,
  input  logic            i_load_we,
  input  logic [SIZE-1:0] i_load_address,
  input  logic [31:0]     i_load_wdata,
  output logic            o_load_ready,
  output logic [31:0]     o_requests,
  output logic [31:0]     o_errors
);

  localparam int unsigned RANGE     = 1 << SIZE;
  localparam logic [32:0] WIN_BYTES = 33'd1 << (SIZE + 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RESPOND} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SIZE-1:0]   idx_q, idx_d;
  logic              in_win_q, in_win_d;
  logic              ready_q, ready_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              error_q, error_d;

  logic [31:0]       mem [RANGE];
  logic [31:0]       bram_rdata_q;
  logic              bram_rd_en;
  logic              load_fire;

  // 33-bit offset: addresses below BASE come out with bit 32 set and fail the compare
  logic [32:0]       offset;
  logic              addr_in_window;
  logic [SIZE-1:0]   addr_index;

  assign offset         = {1'b0, i_bus_address} - {1'b0, BASE};
  assign addr_in_window = offset < WIN_BYTES;
  assign addr_index     = offset[SIZE+1:2];

  assign o_load_ready = i_load_we && (state_q == S_IDLE) && !i_bus_request && !i_reset;
  assign load_fire    = o_load_ready;
  assign bram_rd_en   = (state_q == S_READ) && in_win_q;

  always_ff @(posedge i_clock) begin
    if (load_fire) mem[i_load_address] <= i_load_wdata;
    if (bram_rd_en) bram_rdata_q <= mem[idx_q];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    in_win_d = in_win_q;
    ready_d  = 1'b0;
    rdata_d  = 32'h0;
    error_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_bus_request) begin
          idx_d    = addr_index;
          in_win_d = addr_in_window;
          cnt_d    = 4'(WAIT_STATES);
          state_d  = (WAIT_STATES > 0) ? S_WAIT : S_READ;
        end
      end
      S_WAIT: begin
        if (!i_bus_request) begin
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_READ;
        end
      end
      S_READ: begin
        state_d = i_bus_request ? S_RESPOND : S_IDLE;
      end
      S_RESPOND: begin
        // Pulse is issued even if the initiator has already let go of the request
        ready_d = 1'b1;
        rdata_d = in_win_q ? bram_rdata_q : FILL_WORD;
        error_d = !in_win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      in_win_q <= 1'b0;
      ready_q  <= 1'b0;
      rdata_q  <= 32'h0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      in_win_q <= in_win_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  assign o_bus_ready = ready_q;
  assign o_bus_rdata = rdata_q;
  assign o_bus_error = error_q;

`ifdef FETCH_RESPONDER_STATS_EN
  logic [31:0] req_cnt_q, req_cnt_d;
  logic [31:0] err_cnt_q, err_cnt_d;

  always_comb begin
    req_cnt_d = req_cnt_q;
    err_cnt_d = err_cnt_q;
    if (ready_d) req_cnt_d = req_cnt_q + 32'd1;
    if (ready_d && error_d) err_cnt_d = err_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      req_cnt_q <= 32'h0;
      err_cnt_q <= 32'h0;
    end else begin
      req_cnt_q <= req_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_requests = req_cnt_q;
  assign o_errors   = err_cnt_q;
`else
  assign o_requests = 32'h0;
  assign o_errors   = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_fetch_responder.sv
// Scoreboard bench for cpu_fetch_responder (default parameters, WAIT_STATES=2).
module tb_cpu_fetch_responder;
  localparam int SIZE = 12;
  localparam int LAT  = 5;
  localparam int GAP  = 6;

  logic            i_clock = 1'b0;
  logic            i_reset = 1'b1;
  logic            i_bus_request = 1'b0;
  logic [31:0]     i_bus_address = 32'h0;
  logic            o_bus_ready;
  logic [31:0]     o_bus_rdata;
  logic            o_bus_error;
  logic            i_load_we = 1'b0;
  logic [SIZE-1:0] i_load_address = '0;
  logic [31:0]     i_load_wdata = 32'h0;
  logic            o_load_ready;
  logic [31:0]     o_requests;
  logic [31:0]     o_errors;

  cpu_fetch_responder dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_bus_request(i_bus_request), .i_bus_address(i_bus_address),
    .o_bus_ready(o_bus_ready), .o_bus_rdata(o_bus_rdata), .o_bus_error(o_bus_error),
    .i_load_we(i_load_we), .i_load_address(i_load_address), .i_load_wdata(i_load_wdata),
    .o_load_ready(o_load_ready), .o_requests(o_requests), .o_errors(o_errors)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   last_pulse = -1;
  int   prev_pulse = -1;

  always @(posedge i_clock) cyc <= cyc + 1;

  // Monitor: every ready pulse must match the head of the scoreboard, data and timing
  always @(negedge i_clock) begin
    if (o_bus_ready) begin
      total++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: cycle=%0d rdata=%h err=%b, no transfer outstanding",
                 cyc, o_bus_rdata, o_bus_error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (o_bus_rdata !== e.data || o_bus_error !== e.err || cyc != e.cyc) begin
          bad++;
          $display("FAIL pulse: got rdata=%h err=%b cycle=%0d, want rdata=%h err=%b cycle=%0d",
                   o_bus_rdata, o_bus_error, cyc, e.data, e.err, e.cyc);
        end
      end
    end else begin
      total++;
      if (o_bus_rdata !== 32'h0 || o_bus_error !== 1'b0) begin
        bad++;
        $display("FAIL idle_outputs: cycle=%0d rdata=%h err=%b, want 0/0",
                 cyc, o_bus_rdata, o_bus_error);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge i_clock);
      if (o_bus_ready) seen = 1;
    end
    i_bus_request = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL ready_timeout: got no pulse in 40 cycles, want one");
    end
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input logic err,
                       output int issued);
    exp_t e;
    @(negedge i_clock);
    i_bus_request = 1'b1;
    i_bus_address = addr;
    issued = cyc;
    e.data = data; e.err = err; e.cyc = cyc + LAT;
    sb.push_back(e);
    wait_ready();
  endtask

  task automatic load(input logic [SIZE-1:0] idx, input logic [31:0] d, output int acc);
    bit done = 0;
    acc = -1;
    @(negedge i_clock);
    i_load_we = 1'b1;
    i_load_address = idx;
    i_load_wdata = d;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (o_load_ready) begin
        done = 1;
        acc = cyc;
      end else begin
        @(negedge i_clock);
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL load_timeout: got no o_load_ready in 40 cycles, want acceptance");
    end
    @(negedge i_clock);
    i_load_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, acc;
    // Reset state, with a load request pending to exercise the reset gate
    i_load_we = 1'b1;
    repeat (3) @(negedge i_clock);
    check("rst_ready", 32'(o_bus_ready), 32'h0);
    check("rst_rdata", o_bus_rdata, 32'h0);
    check("rst_error", 32'(o_bus_error), 32'h0);
    check("rst_requests", o_requests, 32'h0);
    check("rst_errors", o_errors, 32'h0);
    check("rst_load_ready", 32'(o_load_ready), 32'h0);
    i_load_we = 1'b0;
    i_reset = 1'b0;

    load(12'd4, 32'hDEADBEEF, acc);
    load(12'd5, 32'hCAFEF00D, acc);
    load(12'd4095, 32'hA5A5A5A5, acc);

    fetch(32'h0000_0010, 32'hDEADBEEF, 1'b0, t0);
    fetch(32'h0000_4000, 32'h0000_0000, 1'b1, t0);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 1'b1, t0);
    fetch(32'h0000_3FFC, 32'hA5A5A5A5, 1'b0, t0);
    fetch(32'h0000_0013, 32'hDEADBEEF, 1'b0, t0);

    // Back-to-back with request low for exactly the ready cycle
    fetch(32'h0000_0010, 32'hDEADBEEF, 1'b0, t0);
    fetch(32'h0000_0014, 32'hCAFEF00D, 1'b0, t1);
    check("b2b_gap", 32'(last_pulse - prev_pulse), 32'(GAP));

    // Load arriving during a fetch waits for IDLE; fetch still sees old data
    fork
      fetch(32'h0000_0010, 32'hDEADBEEF, 1'b0, t0);
      load(12'd4, 32'h1234_5678, acc);
    join
    check("load_accept_cycle", 32'(acc), 32'(t0 + LAT));
    fetch(32'h0000_0010, 32'h1234_5678, 1'b0, t0);

    // Reset while in WAIT with request held: old transfer dropped, fresh one follows
    begin
      exp_t e;
      @(negedge i_clock);
      i_bus_request = 1'b1;
      i_bus_address = 32'h0000_0010;
      @(negedge i_clock);
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      e.data = 32'h1234_5678; e.err = 1'b0; e.cyc = cyc + LAT;
      sb.push_back(e);
      wait_ready();
    end

    // Statistics run from a clean reset, then an aborted transfer
    do_reset();
    fetch(32'h0000_0010, 32'h1234_5678, 1'b0, t0);
    fetch(32'h0000_0014, 32'hCAFEF00D, 1'b0, t0);
    fetch(32'h0000_3FFC, 32'hA5A5A5A5, 1'b0, t0);
    fetch(32'h0000_4000, 32'h0000_0000, 1'b1, t0);
    fetch(32'hFFFF_FFFC, 32'h0000_0000, 1'b1, t0);
    @(negedge i_clock);
    i_bus_request = 1'b1;
    i_bus_address = 32'h0000_0010;
    @(negedge i_clock);
    @(negedge i_clock);
    i_bus_request = 1'b0;
    repeat (10) @(negedge i_clock);
`ifdef FETCH_RESPONDER_STATS_EN
    check("stats_requests", o_requests, 32'd5);
    check("stats_errors", o_errors, 32'd2);
`else
    check("stats_requests_off", o_requests, 32'd0);
    check("stats_errors_off", o_errors, 32'd0);
`endif
    fetch(32'h0000_0014, 32'hCAFEF00D, 1'b0, t0);

    repeat (3) @(negedge i_clock);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
